// File: rtl/serial_add_pkg.sv
// rtl/serial_add_pkg.sv - shared state encoding and defaults for the bit-serial adder
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/bit_serial_fa.sv
// rtl/bit_serial_fa.sv - combinational 1-bit full-adder cell
module bit_serial_fa (
  input  logic x,
  input  logic y,
  input  logic z,
  output logic s,
  output logic co
);

  always_comb begin
    s  = x ^ y ^ z;
    co = (x & y) | (x & z) | (y & z);
  end

endmodule

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial adder controller, one sum bit per cycle LSB first
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             done_q, done_d;

  logic fa_s;
  logic fa_co;

  bit_serial_fa u_fa (
    .x  (a_q[0]),
    .y  (b_q[0]),
    .z  (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Each new bit enters at the MSB so the first (LSB) bit ends at index 0.
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        sum_d   = {fa_s, sum_q[WIDTH-1:1]};
        carry_d = fa_co;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          cout_d  = fa_co;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    ready = (state_q == IDLE);
    busy  = (state_q == RUN);
    done  = done_q;
    sum   = sum_q;
    cout  = cout_q;
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - directed self-checking bench for serial_add_ctrl (WIDTH 4 and 8)
module tb_serial_add_ctrl;

  logic       clk;
  logic       rst_n;

  logic       start4;
  logic [3:0] a4, b4;
  logic       cin4;
  logic       ready4, busy4, done4, cout4;
  logic [3:0] sum4;

  logic       start8;
  logic [7:0] a8, b8;
  logic       cin8;
  logic       ready8, busy8, done8, cout8;
  logic [7:0] sum8;

  int n_checks;
  int n_fail;
  int lat;
  int busy_n;
  int n_done;
  logic [3:0] cap_sum;
  logic       cap_cout;

  serial_add_ctrl #(.WIDTH(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start4),
    .a     (a4),
    .b     (b4),
    .cin   (cin4),
    .ready (ready4),
    .busy  (busy4),
    .done  (done4),
    .sum   (sum4),
    .cout  (cout4)
  );

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .cin   (cin8),
    .ready (ready8),
    .busy  (busy8),
    .done  (done8),
    .sum   (sum8),
    .cout  (cout8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Called at a negedge; returns the number of cycles until done is seen.
  task automatic op4(input logic [3:0] ta, input logic [3:0] tb, input logic tci,
                     input logic hold, output int l, output int bn);
    a4 = ta;
    b4 = tb;
    cin4 = tci;
    start4 = 1'b1;
    l = 0;
    bn = 0;
    while (l < 20) begin
      @(posedge clk);
      @(negedge clk);
      l++;
      if (!hold) start4 = 1'b0;
      if (busy4) bn++;
      if (done4) break;
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst_n = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_ready", 32'(ready4), 32'd1);
    check("rst_busy", 32'(busy4), 32'd0);
    check("rst_done", 32'(done4), 32'd0);
    check("rst_sum", 32'(sum4), 32'd0);
    check("rst_cout", 32'(cout4), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_ready", 32'(ready4), 32'd1);

    // 0110 + 1100 = 1_0010
    op4(4'b0110, 4'b1100, 1'b0, 1'b0, lat, busy_n);
    check("s1_done", 32'(done4), 32'd1);
    check("s1_latency", 32'(lat), 32'd5);
    check("s1_busy_cycles", 32'(busy_n), 32'd4);
    check("s1_sum", 32'(sum4), 32'b0010);
    check("s1_cout", 32'(cout4), 32'd1);
    check("s1_ready_in_done", 32'(ready4), 32'd0);
    @(negedge clk);
    check("s1_ready_after", 32'(ready4), 32'd1);
    check("s1_done_pulse", 32'(done4), 32'd0);
    repeat (3) @(negedge clk);
    check("s1_sum_held", 32'(sum4), 32'b0010);
    check("s1_cout_held", 32'(cout4), 32'd1);

    // Back-to-back with start held: 1010+0110 then 0010+1000
    op4(4'b1010, 4'b0110, 1'b0, 1'b1, lat, busy_n);
    check("s2a_done", 32'(done4), 32'd1);
    check("s2a_sum", 32'(sum4), 32'b0000);
    check("s2a_cout", 32'(cout4), 32'd1);
    op4(4'b0010, 4'b1000, 1'b0, 1'b1, lat, busy_n);
    start4 = 1'b0;
    check("s2b_done", 32'(done4), 32'd1);
    check("s2b_spacing", 32'(lat), 32'd6);
    check("s2b_sum", 32'(sum4), 32'b1010);
    check("s2b_cout", 32'(cout4), 32'd0);
    repeat (2) @(negedge clk);

    // Carry-in ripples through every bit
    op4(4'b1111, 4'b0000, 1'b1, 1'b0, lat, busy_n);
    check("s3a_done", 32'(done4), 32'd1);
    check("s3a_sum", 32'(sum4), 32'b0000);
    check("s3a_cout", 32'(cout4), 32'd1);
    @(negedge clk);
    op4(4'b0000, 4'b0000, 1'b0, 1'b0, lat, busy_n);
    check("s3b_done", 32'(done4), 32'd1);
    check("s3b_sum", 32'(sum4), 32'b0000);
    check("s3b_cout", 32'(cout4), 32'd0);
    @(negedge clk);

    // Start during RUN is ignored: 0101 + 0011 = 1000
    a4 = 4'b0101; b4 = 4'b0011; cin4 = 1'b0; start4 = 1'b1;
    @(posedge clk); @(negedge clk);
    start4 = 1'b0;
    @(posedge clk); @(negedge clk);
    a4 = 4'b1111; b4 = 4'b1111; cin4 = 1'b1; start4 = 1'b1;
    @(posedge clk); @(negedge clk);
    start4 = 1'b0;
    check("s4_busy", 32'(busy4), 32'd1);
    n_done = 0;
    cap_sum = '0;
    cap_cout = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (done4) begin
        n_done++;
        cap_sum = sum4;
        cap_cout = cout4;
      end
      @(negedge clk);
    end
    check("s4_done_count", 32'(n_done), 32'd1);
    check("s4_sum", 32'(cap_sum), 32'b1000);
    check("s4_cout", 32'(cap_cout), 32'd0);
    check("s4_ready", 32'(ready4), 32'd1);

    // Reset aborts mid-RUN
    a4 = 4'b1111; b4 = 4'b0001; cin4 = 1'b0; start4 = 1'b1;
    @(posedge clk); @(negedge clk);
    start4 = 1'b0;
    @(posedge clk); @(negedge clk);
    check("s5_busy_pre", 32'(busy4), 32'd1);
    rst_n = 1'b0;
    #1;
    check("s5_ready", 32'(ready4), 32'd1);
    check("s5_busy", 32'(busy4), 32'd0);
    check("s5_sum", 32'(sum4), 32'd0);
    check("s5_cout", 32'(cout4), 32'd0);
    n_done = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done4) n_done++;
    end
    check("s5_no_done", 32'(n_done), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done4) n_done++;
    end
    check("s5_no_done_after", 32'(n_done), 32'd0);
    op4(4'b0011, 4'b0001, 1'b0, 1'b0, lat, busy_n);
    check("s5b_done", 32'(done4), 32'd1);
    check("s5b_sum", 32'(sum4), 32'b0100);
    check("s5b_cout", 32'(cout4), 32'd0);
    @(negedge clk);

    // WIDTH=8: 0xF0 + 0x20 = 0x110
    check("w8_ready", 32'(ready8), 32'd1);
    a8 = 8'hF0; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
    lat = 0;
    busy_n = 0;
    while (lat < 30) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
      start8 = 1'b0;
      if (busy8) busy_n++;
      if (done8) break;
    end
    check("w8_done", 32'(done8), 32'd1);
    check("w8_latency", 32'(lat), 32'd9);
    check("w8_busy_cycles", 32'(busy_n), 32'd8);
    check("w8_sum", 32'(sum8), 32'h10);
    check("w8_cout", 32'(cout8), 32'd1);
    @(negedge clk);
    check("w8_ready_after", 32'(ready8), 32'd1);
    check("w8_done_pulse", 32'(done8), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Bit-serial adder controller. It sequences a single 1-bit full-adder cell over WIDTH clock cycles to produce a WIDTH-bit sum and carry-out. It is an area-reduced alternative to the ripple adder, used where throughput is not critical. Operands are accepted through a start/ready handshake, and completion is signalled by a one-cycle done pulse.

Parameters:
WIDTH, 4, operand/sum width in bits; legal range 2..32.
CNT_W, $clog2(WIDTH+1), bit-index counter width; derived, not overridden.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request to begin an addition; sampled only when ready=1
a  input  WIDTH  operand A; captured on accepted start
b  input  WIDTH  operand B; captured on accepted start
cin  input  1  carry-in; captured on accepted start
ready  output  1  high in IDLE only; start is accepted when start&ready
busy  output  1  high in RUN
done  output  1  one-cycle pulse when sum/cout become valid
sum  output  WIDTH  result; held stable from done until the next accepted start
cout  output  1  final carry; same validity as sum

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, counter=0, carry flop=0, operand shift registers=0.
  - sum=0, cout=0, done=0, busy=0, ready=1.
- States: IDLE, RUN, DONE.
- IDLE -> RUN on the edge where start&ready:
  - latch a into shift reg A and b into shift reg B.
  - carry flop <= cin; counter <= 0.
  - sum register cleared to 0, cout <= 0.
- RUN, each edge:
  - cell computes s = A[0]^B[0]^c and co = majority(A[0],B[0],c).
  - A and B shift right by 1.
  - s shifts into sum MSB (sum shifts right), so LSB-first bits land in the correct positions after WIDTH shifts.
  - carry flop <= co; counter += 1.
- RUN -> DONE on the edge where counter == WIDTH-1 (the WIDTH-th bit is processed). On that edge: cout <= co and done <= 1.
- DONE -> IDLE unconditionally on the next edge; done <= 0.
- Latency: start accepted at edge k; done is high in the cycle after edge k+WIDTH; ready returns at edge k+WIDTH+1. Throughput is one addition per WIDTH+2 cycles.
- start while RUN or DONE is ignored: operands are not re-latched and there is no error flag.
- start held high continuously: a new operation begins every WIDTH+2 cycles.
- a, b, cin changing during RUN have no effect.
- Arithmetic is modulo 2^WIDTH; overflow is reported only through cout. No sign handling.
- During RUN, sum holds partial shifted bits and is not valid; consumers must qualify with done.
- rst_n asserted mid-RUN aborts the operation immediately: all reset values apply, with no done pulse.
- rst_n deasserts synchronously to clk externally (reset synchroniser lives outside this block).

Decomposition:
- Shared package serial_add_pkg:
  - state enum {IDLE, RUN, DONE}, 2-bit encoding.
  - default WIDTH constant.
- Single sub-module bit_serial_fa: combinational 1-bit full adder (x, y, z -> s, co). It is instantiated once; the carry flop stays in the controller.
- No other hierarchy.

Test Plan:
- 0110 + 1100, cin=0, start for 1 cycle -> busy for 4 cycles, then done pulse; sum=0010, cout=1; ready high on the following cycle.
- 1010 + 0110, cin=0 -> sum=0000, cout=1. Then 0010 + 1000, cin=0 back-to-back, with start held high -> sum=1010, cout=0; second done exactly 6 cycles after the first.
- 1111 + 0000, cin=1 -> sum=0000, cout=1 (carry-in ripples through all bits); 0000 + 0000, cin=0 -> sum=0000, cout=0.
- Start 0101 + 0011 accepted, then start pulsed with 1111 + 1111 during RUN -> result sum=1000, cout=0; second request ignored, single done pulse.
- Start 1111 + 0001, assert rst_n=0 after 2 RUN cycles -> sum=0, cout=0, done never pulses, ready=1 immediately; after release, 0011 + 0001 -> sum=0100, cout=0.
- Repeat the first scenario with WIDTH=8, 0xF0 + 0x20 -> done 9 cycles after accept; sum=0x10, cout=1.
